// File: rtl/jedro_1_ifu_pkg.sv
// Shared types and constants for the jedro_1 instruction fetch unit.
package jedro_1_ifu_pkg;

    localparam logic [31:0] JEDRO_1_NOP       = 32'h0000_0013;
    localparam logic [31:0] JEDRO_1_BOOT_ADDR = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } ifu_entry_t;

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Prefetch FIFO of {instr, addr} entries; flush takes priority over push.
module jedro_1_ifu_fifo
    import jedro_1_ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  ifu_entry_t data_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output ifu_entry_t data_o,
    output logic       empty_o,
    output logic       full_o,
    output logic [AW:0] count_o
);

    ifu_entry_t  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign count_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: PC, ROM read port, prefetch FIFO.
// Optional misaligned-jump trap via JEDRO_1_IFU_MISALIGN_CHECK_EN.
module jedro_1_ifu
    import jedro_1_ifu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = JEDRO_1_BOOT_ADDR,
    parameter int          DEPTH     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_rd_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_addr_i,
    output logic        instr_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o
`ifdef JEDRO_1_IFU_MISALIGN_CHECK_EN
    ,
    output logic        misaligned_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        inflight_q, inflight_d;
    logic [31:0] jmp_tgt;
    logic        jmp_bad;
    logic        blocked;
    logic        push, pop, empty, full;
    logic [AW:0] count;
    logic [CW-1:0] occ;
    ifu_entry_t  wr_entry, head;

`ifdef JEDRO_1_IFU_MISALIGN_CHECK_EN
    logic mis_q, mis_d;

    assign jmp_tgt = jmp_addr_i;
    assign jmp_bad = jmp_i & (|jmp_addr_i[1:0]);
    assign mis_d   = jmp_i ? jmp_bad : mis_q;
    assign blocked = mis_q;
    assign misaligned_o = mis_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end
`else
    assign jmp_tgt = jmp_addr_i & ~32'h3;
    assign jmp_bad = 1'b0;
    assign blocked = 1'b0;
`endif

    assign instr_valid_o = ~empty & ~jmp_i & ~blocked;
    assign pop  = instr_valid_o & dec_ready_i;
    assign push = inflight_q & ~jmp_i;
    // Words already buffered or on their way, after this cycle's pop.
    assign occ  = CW'(count) + CW'(inflight_q) - CW'(pop);

    assign imem_addr_o = jmp_i ? jmp_tgt : pc_q;
    assign imem_rd_o   = ~rst_i &
                         (jmp_i ? ~jmp_bad : (~blocked & (occ < CW'(DEPTH))));

    always_comb begin
        pc_d       = pc_q;
        addr_d     = addr_q;
        inflight_d = imem_rd_o;
        if (imem_rd_o) begin
            pc_d   = imem_addr_o + 32'd4;
            addr_d = imem_addr_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= BOOT_ADDR;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
        end
    end

    assign wr_entry = '{instr: imem_data_i, addr: addr_q};

    jedro_1_ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .flush_i (jmp_i),
        .data_o  (head),
        .empty_o (empty),
        .full_o  (full),
        .count_o (count)
    );

    assign instr_o      = head.instr;
    assign instr_addr_o = head.addr;

    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Directed self-checking bench for jedro_1_ifu with a synchronous ROM model.
module tb_jedro_1_ifu;

    logic        clk;
    logic        rst;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        jmp;
    logic [31:0] jmp_addr;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] iaddr;
`ifdef JEDRO_1_IFU_MISALIGN_CHECK_EN
    logic        mis;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_a;

    localparam logic [31:0] BOOT = 32'h8000_0000;

    jedro_1_ifu #(.BOOT_ADDR(BOOT), .DEPTH(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_rd_o     (imem_rd),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .jmp_i         (jmp),
        .jmp_addr_i    (jmp_addr),
        .instr_valid_o (valid),
        .dec_ready_i   (ready),
        .instr_o       (instr),
        .instr_addr_o  (iaddr)
`ifdef JEDRO_1_IFU_MISALIGN_CHECK_EN
        ,
        .misaligned_o  (mis)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h8000_0000: rom = 32'h0000_0093;
            32'h8000_0004: rom = 32'h0010_0113;
            default:       rom = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (imem_rd) imem_data <= rom(imem_addr);
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            ready = 1'b1;
            #1;
            chk("stream_valid", 32'(valid), 32'd1);
            chk("stream_addr", iaddr, exp_a);
            chk("stream_instr", instr, rom(exp_a));
            exp_a = exp_a + 32'd4;
        end
    endtask

    initial begin
        rst = 1'b1;
        ready = 1'b1;
        jmp = 1'b0;
        jmp_addr = '0;
        imem_data = '0;
        #3;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_rd", 32'(imem_rd), 32'd0);
`ifdef JEDRO_1_IFU_MISALIGN_CHECK_EN
        chk("rst_mis", 32'(mis), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("c0_rd", 32'(imem_rd), 32'd1);
        chk("c0_addr", imem_addr, BOOT);
        chk("c0_valid", 32'(valid), 32'd0);
        cyc();
        #1;
        chk("c1_valid", 32'(valid), 32'd0);
        exp_a = BOOT;
        stream(2);

        // Backpressure: head 0x80000008 must hold, fetch must stall.
        for (int k = 0; k < 5; k++) begin
            cyc();
            ready = 1'b0;
            #1;
            chk("bp_valid", 32'(valid), 32'd1);
            chk("bp_addr", iaddr, 32'h8000_0008);
            chk("bp_instr", instr, rom(32'h8000_0008));
            if (k >= 1) chk("bp_rd", 32'(imem_rd), 32'd0);
        end
        exp_a = 32'h8000_0008;
        stream(6);

        for (int k = 0; k < 3; k++) begin
            cyc();
            ready = 1'b0;
        end
        #1;
        chk("full_rd", 32'(imem_rd), 32'd0);

        cyc();
        jmp = 1'b1;
        jmp_addr = 32'h8000_0010;
        #1;
        chk("jf_valid", 32'(valid), 32'd0);
        chk("jf_rd", 32'(imem_rd), 32'd1);
        chk("jf_addr", imem_addr, 32'h8000_0010);
        cyc();
        jmp = 1'b0;
        ready = 1'b1;
        #1;
        chk("jf_n1_valid", 32'(valid), 32'd0);
        exp_a = 32'h8000_0010;
        stream(4);

        cyc();
        ready = 1'b1;
        jmp = 1'b1;
        jmp_addr = 32'h8000_0040;
        #1;
        chk("jr_valid", 32'(valid), 32'd0);
        chk("jr_rd", 32'(imem_rd), 32'd1);
        cyc();
        jmp = 1'b0;
        #1;
        chk("jr_n1_valid", 32'(valid), 32'd0);
        exp_a = 32'h8000_0040;
        stream(3);

        // Mid-stream reset with a response in flight.
        cyc();
        #1;
        rst = 1'b1;
        #1;
        chk("mr_valid", 32'(valid), 32'd0);
        chk("mr_instr", instr, 32'd0);
        chk("mr_iaddr", iaddr, 32'd0);
        chk("mr_rd", 32'(imem_rd), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_c0_rd", 32'(imem_rd), 32'd1);
        chk("mr_c0_addr", imem_addr, BOOT);
        cyc();
        #1;
        chk("mr_c1_valid", 32'(valid), 32'd0);
        exp_a = BOOT;
        stream(2);

`ifdef JEDRO_1_IFU_MISALIGN_CHECK_EN
        cyc();
        jmp = 1'b1;
        jmp_addr = 32'h8000_0006;
        #1;
        chk("ma_rd", 32'(imem_rd), 32'd0);
        chk("ma_valid", 32'(valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            jmp = 1'b0;
            #1;
            chk("ma_flag", 32'(mis), 32'd1);
            chk("ma_hold_rd", 32'(imem_rd), 32'd0);
            chk("ma_hold_valid", 32'(valid), 32'd0);
        end
        cyc();
        jmp = 1'b1;
        jmp_addr = 32'h8000_0008;
        #1;
        chk("al_rd", 32'(imem_rd), 32'd1);
        chk("al_addr", imem_addr, 32'h8000_0008);
        cyc();
        jmp = 1'b0;
        #1;
        chk("al_flag", 32'(mis), 32'd0);
        chk("al_n1_valid", 32'(valid), 32'd0);
        exp_a = 32'h8000_0008;
        stream(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
